// File: rtl/midi_out.sv
// midi_out -- MIDI message transmitter.
//
// The block takes one complete MIDI message per VALID/READY handshake and works
// out its length from the status byte. It drops the status byte when running
// status allows it, then sends the remaining bytes as 8N1 UART frames at
// BIT_CYCLES clock cycles per bit.
//
// Ports:
//   IN_CLOCK       system clock
//   IN_RESET       synchronous active-high reset
//   IN_MSG_VALID   message present on IN_STATUS / IN_DATA1 / IN_DATA2
//   IN_MSG_READY   registered; high only while idle
//   IN_STATUS      status byte
//   IN_DATA1       first data byte (sent with bit 7 = 0)
//   IN_DATA2       second data byte (sent with bit 7 = 0)
//   IN_RUNNING_EN  running-status enable, sampled at accept
//   OUT_TX         UART line, idle high
//   OUT_BUSY       high from accept until the last stop bit ends
//   OUT_BYTE_DONE  one-cycle pulse in the last cycle of each stop bit
//   OUT_ERR        one-cycle pulse after an invalid (status < 0x80) accept
module midi_out #(
    parameter int unsigned BIT_CYCLES = 1600
) (
    input  logic       IN_CLOCK,
    input  logic       IN_RESET,
    input  logic       IN_MSG_VALID,
    output logic       IN_MSG_READY,
    input  logic [7:0] IN_STATUS,
    input  logic [6:0] IN_DATA1,
    input  logic [6:0] IN_DATA2,
    input  logic       IN_RUNNING_EN,
    output logic       OUT_TX,
    output logic       OUT_BUSY,
    output logic       OUT_BYTE_DONE,
    output logic       OUT_ERR
);

    localparam int unsigned TW = (BIT_CYCLES > 2) ? $clog2(BIT_CYCLES) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(BIT_CYCLES - 1);
    localparam logic [TW-1:0] T_PRE  = TW'(BIT_CYCLES - 2);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t          r_state;
    logic [TW-1:0]   r_timer;
    logic [2:0]      r_bit;
    logic [1:0]      r_left;      // bytes still to send after the current one
    logic [7:0]      r_shift;     // byte currently on the line, shifted LSB first
    logic [7:0]      r_msg1;
    logic [7:0]      r_msg2;
    logic [7:0]      r_rs;
    logic            r_rs_valid;
    logic            r_tx;
    logic            r_busy;
    logic            r_ready;
    logic            r_byte_done;
    logic            r_err;

    logic [1:0]      w_len;
    logic            w_is_chan;
    logic            w_is_common;
    logic            w_skip;
    logic            w_accept;

    always_comb begin
        w_len = 2'd0;
        case (IN_STATUS[7:4])
            4'h8, 4'h9, 4'hA, 4'hB, 4'hE: w_len = 2'd3;
            4'hC, 4'hD:                   w_len = 2'd2;
            4'hF: begin
                case (IN_STATUS[3:0])
                    4'h2:       w_len = 2'd3;
                    4'h1, 4'h3: w_len = 2'd2;
                    default:    w_len = 2'd1;
                endcase
            end
            default:                      w_len = 2'd0;
        endcase
    end

    assign w_is_chan   = IN_STATUS[7] && (IN_STATUS[7:4] != 4'hF);
    assign w_is_common = (IN_STATUS[7:3] == 5'b11110);
    assign w_skip      = IN_RUNNING_EN && w_is_chan && r_rs_valid && (r_rs == IN_STATUS);
    assign w_accept    = IN_MSG_VALID && r_ready;

    always_ff @(posedge IN_CLOCK) begin
        if (IN_RESET) begin
            r_state     <= S_IDLE;
            r_timer     <= '0;
            r_bit       <= '0;
            r_left      <= '0;
            r_shift     <= '0;
            r_msg1      <= '0;
            r_msg2      <= '0;
            r_rs        <= '0;
            r_rs_valid  <= 1'b0;
            r_tx        <= 1'b1;
            r_busy      <= 1'b0;
            r_ready     <= 1'b1;
            r_byte_done <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_byte_done <= 1'b0;
            r_err       <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        if (!IN_STATUS[7]) begin
                            // Invalid status: flag it, stay idle and ready.
                            r_err <= 1'b1;
                        end else begin
                            // Byte queue: r_shift is sent first, then r_msg1, r_msg2.
                            if (w_skip) begin
                                r_shift <= {1'b0, IN_DATA1};
                                r_msg1  <= {1'b0, IN_DATA2};
                                r_msg2  <= '0;
                                r_left  <= w_len - 2'd2;
                            end else begin
                                r_shift <= IN_STATUS;
                                r_msg1  <= {1'b0, IN_DATA1};
                                r_msg2  <= {1'b0, IN_DATA2};
                                r_left  <= w_len - 2'd1;
                            end
                            if (w_is_chan) begin
                                r_rs       <= IN_STATUS;
                                r_rs_valid <= 1'b1;
                            end else if (w_is_common) begin
                                r_rs_valid <= 1'b0;
                            end
                            r_state <= S_START;
                            r_timer <= '0;
                            r_tx    <= 1'b0;
                            r_busy  <= 1'b1;
                            r_ready <= 1'b0;
                        end
                    end
                end
                S_START: begin
                    if (r_timer == T_LAST) begin
                        r_timer <= '0;
                        r_bit   <= '0;
                        r_tx    <= r_shift[0];
                        r_shift <= {1'b0, r_shift[7:1]};
                        r_state <= S_DATA;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                S_DATA: begin
                    if (r_timer == T_LAST) begin
                        r_timer <= '0;
                        if (r_bit == 3'd7) begin
                            r_tx    <= 1'b1;
                            r_state <= S_STOP;
                        end else begin
                            r_bit   <= r_bit + 3'd1;
                            r_tx    <= r_shift[0];
                            r_shift <= {1'b0, r_shift[7:1]};
                        end
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                S_STOP: begin
                    // Registered pulse: raised one cycle early so it lands on the last stop cycle.
                    if (r_timer == T_PRE) begin
                        r_byte_done <= 1'b1;
                    end
                    if (r_timer == T_LAST) begin
                        r_timer <= '0;
                        if (r_left != 2'd0) begin
                            r_shift <= r_msg1;
                            r_msg1  <= r_msg2;
                            r_left  <= r_left - 2'd1;
                            r_tx    <= 1'b0;
                            r_state <= S_START;
                        end else begin
                            r_busy  <= 1'b0;
                            r_ready <= 1'b1;
                            r_state <= S_IDLE;
                        end
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign IN_MSG_READY  = r_ready;
    assign OUT_TX        = r_tx;
    assign OUT_BUSY      = r_busy;
    assign OUT_BYTE_DONE = r_byte_done;
    assign OUT_ERR       = r_err;

endmodule

// File: doc/midi_out.md
# midi_out

MIDI message transmitter: accepts one complete MIDI channel/system message per handshake, determines its length from the status byte, optionally suppresses the status byte under running status, and serialises the bytes as 31250-baud UART frames on a single output line. It is the transmit-side counterpart of the MIDI input path, used to echo/forward parsed events or drive an external MIDI device from the synthesizer's clock domain (CLK_50MHZ).

## Interface
- BIT_CYCLES, 1600: clock cycles per UART bit (50 MHz / 31250 baud); benches override to small values (e.g. 4); must be ≥ 2.
- IN_CLOCK  in  1  system clock (CLK_50MHZ).
- IN_RESET  in  1  synchronous, active-high reset.
- IN_MSG_VALID  in  1  message present on IN_STATUS/IN_DATA1/IN_DATA2.
- IN_MSG_READY  out  1  block can accept a message; transfer when VALID && READY on a rising edge.
- IN_STATUS  in  8  status byte.
- IN_DATA1  in  7  first data byte (sent with bit 7 = 0).
- IN_DATA2  in  7  second data byte (sent with bit 7 = 0).
- IN_RUNNING_EN  in  1  running-status enable, sampled at accept.
- OUT_TX  out  1  MIDI UART line, idle high.
- OUT_BUSY  out  1  high from accept until last stop bit ends.
- OUT_BYTE_DONE  out  1  one-cycle pulse at end of each transmitted byte's stop bit.
- OUT_ERR  out  1  one-cycle pulse when an invalid message is accepted.

## Operation
- Reset: OUT_TX=1, IN_MSG_READY=1, OUT_BUSY=0, OUT_BYTE_DONE=0, OUT_ERR=0, running-status register cleared (invalid), state IDLE. Reset mid-frame aborts immediately; no partial frame completion.
- Message length by IN_STATUS: 0x80–0xBF, 0xE0–0xEF, 0xF2 → 3 bytes; 0xC0–0xDF, 0xF1, 0xF3 → 2 bytes; 0xF0, 0xF4–0xFF → 1 byte (status only).
- IN_STATUS < 0x80: invalid; accepted, OUT_ERR pulses the next cycle, nothing transmitted, READY stays high, running status unchanged.
- Running status: register holds last transmitted channel status (0x80–0xEF). If IN_RUNNING_EN=1, status is channel, and equals valid register → status byte skipped, only data bytes sent. Otherwise status byte sent and register updated with channel status.
- 0xF0–0xF7 (system common/exclusive): sent, invalidates running status. 0xF8–0xFF (real-time): sent, running status untouched.
- IN_RUNNING_EN=0 never skips but still updates the register.
- Byte order: status (if sent), DATA1, DATA2. Data bytes transmitted as {1'b0, DATAn}.
- Frame: start bit 0, 8 data bits LSB first, stop bit 1; each bit exactly BIT_CYCLES cycles.
- States: IDLE → (accept, valid) START → DATA (8 bits, bit index 0–7) → STOP → START of next byte if bytes remain, else IDLE. Invalid accept: IDLE → IDLE.
- Counters: bit-timer width clog2(BIT_CYCLES), counts 0..BIT_CYCLES-1 and wraps; bit index 3 bits; byte counter 2 bits.

## Timing
- IN_MSG_READY high only in IDLE and not in the cycle of an accept; registered (no combinational VALID→READY path).
- Inputs latched at accept edge; changes afterwards have no effect.
- OUT_TX falls on the first cycle after accept (1-cycle latency); OUT_BUSY rises same cycle.
- Byte duration 10·BIT_CYCLES cycles; consecutive bytes back-to-back, no idle gap.
- OUT_BYTE_DONE pulses in the last cycle of each stop bit.
- After last byte's stop bit, OUT_BUSY=0 and IN_MSG_READY=1 in the next cycle; a new message may be accepted that cycle, its start bit follows one cycle later (minimum idle of 1 cycle between messages).
- Total message time: N·10·BIT_CYCLES cycles, N = transmitted byte count.
- VALID with READY low: ignored, no queuing.

## Test plan
- BIT_CYCLES=4, send 0x90/0x3C/0x64, RUNNING_EN=0 → OUT_TX shows 0x90, 0x3C, 0x64 frames LSB first, 120 busy cycles, 3 BYTE_DONE pulses, READY back after cycle 120.
- Running status: 0x90/0x3C/0x64 then 0x90/0x40/0x00 with RUNNING_EN=1 → second message sends only 0x40, 0x00 (80 cycles); then 0x80/0x40/0x00 → status 0x80 transmitted.
- Real-time vs common: 0x91 msg, then 0xF8 (1 byte, 40 cycles), then 0x91 msg with RUNNING_EN=1 → status skipped; repeat with 0xF6 in between → status 0x91 resent.
- Lengths: 0xC5/0x07 → 2 bytes (0xC5, 0x07), DATA2 ignored; 0xF3/0x05 → 2 bytes; 0xFF → 1 byte.
- Invalid 0x3C → OUT_ERR one pulse, OUT_TX stays 1, READY stays high, following running-status decision unchanged.
- Assert IN_RESET during DATA bit 3 of second byte → next cycle OUT_TX=1, READY=1, BUSY=0; subsequent 0x90 msg with RUNNING_EN=1 sends status byte (register cleared).
